// File: rtl/spike_rate_encoder_2ch.sv
// Two-channel rate encoder: each accepted value pair becomes an evenly spaced
// spike train per channel over WINDOW cycles, then GAP_CYCLES of silence.
module spike_rate_encoder_2ch #(
  parameter int VALUE_WIDTH = 4,
  parameter int WINDOW      = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VALUE_WIDTH-1:0] in_value1,
  input  logic [VALUE_WIDTH-1:0] in_value2,
  output logic                   out1,
  output logic                   out2,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_MAX = (WINDOW > GAP_CYCLES) ? WINDOW : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [VALUE_WIDTH-1:0] v1, v2;
  logic [VALUE_WIDTH-1:0] acc1, acc2;

  // Carry out of the W-bit accumulator is the spike; the low bits wrap.
  function automatic logic [VALUE_WIDTH:0] acc_step(input logic [VALUE_WIDTH-1:0] acc,
                                                    input logic [VALUE_WIDTH-1:0] v);
    return {1'b0, acc} + {1'b0, v};
  endfunction

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (cnt == WIN_LAST) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:  if (cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      v1   <= '0;
      v2   <= '0;
      acc1 <= '0;
      acc2 <= '0;
      out1 <= 1'b0;
      out2 <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out1 <= 1'b0;
          out2 <= 1'b0;
          done <= 1'b0;
          cnt  <= '0;
          if (in_valid) begin
            v1   <= in_value1;
            v2   <= in_value2;
            acc1 <= '0;
            acc2 <= '0;
            busy <= 1'b1;
          end
        end
        RUN: begin
          {out1, acc1} <= acc_step(acc1, v1);
          {out2, acc2} <= acc_step(acc2, v2);
          if (cnt == WIN_LAST) begin
            cnt <= '0;
            if (GAP_CYCLES == 0) begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          out1 <= 1'b0;
          out2 <= 1'b0;
          if (cnt == GAP_LAST) begin
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          out1 <= 1'b0;
          out2 <= 1'b0;
        end
      endcase
    end
  end

endmodule
